// File: rtl/exponential_param_if.sv
// exponential_param_if
// Handshake/result bundle for the exponential unit.
//   start/neg/x             : request from the controller (master -> slave)
//   busy/done               : run status, done is a one-cycle pulse
//   intpart/fracpart/ovf    : registered result, held until the next done
interface exponential_param_if #(
    parameter int FRAC_W = 16,
    parameter int INT_W  = 2
);
    logic              start;
    logic              neg;
    logic [FRAC_W-1:0] x;
    logic              busy;
    logic              done;
    logic [INT_W-1:0]  intpart;
    logic [FRAC_W-1:0] fracpart;
    logic              ovf;

    modport master (
        output start, neg, x,
        input  busy, done, intpart, fracpart, ovf
    );

    modport slave (
        input  start, neg, x,
        output busy, done, intpart, fracpart, ovf
    );
endinterface

// File: rtl/exponential_param.sv
// exponential_param
// Computes e^x or e^-x for x in [0,1) (x = bus.x / 2^FRAC_W) with a
// Horner-form Taylor series of TERMS terms and one shared multiplier:
//   acc = 1; for k = TERMS..1: acc = 1 +/- (acc*x)/k
// Each term takes two cycles (MUL, SCALE); division by k is a multiply by
// a rounded reciprocal constant.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous, active-low reset (aborts a run, clears outputs)
//   bus  : slave side of exponential_param_if (start/neg/x in,
//          busy/done/intpart/fracpart/ovf out, all outputs registered)
module exponential_param #(
    parameter int FRAC_W = 16,
    parameter int INT_W  = 2,
    parameter int TERMS  = 8
) (
    input  logic                clk,
    input  logic                rst,
    exponential_param_if.slave  bus
);
    localparam int W = INT_W + FRAC_W;

    // 1.0 in the widened (W+2 bit) sum domain
    localparam logic [W+1:0] ONE = {{(W+1){1'b0}}, 1'b1} << FRAC_W;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_SCALE, S_DONE} state_t;

    // round(2^FRAC_W / k); only ever called with constant k
    function automatic logic [FRAC_W:0] recip_f(input int k);
        logic [63:0] num;
        if (k == 0) return '0;
        num = (64'd1 << FRAC_W) + 64'(k / 2);
        return (FRAC_W+1)'(num / 64'(k));
    endfunction

    logic [FRAC_W:0] recip_rom [16];
    for (genvar g = 0; g < 16; g++) begin : g_rom
        assign recip_rom[g] = recip_f(g);
    end

    state_t            state_q, state_d;
    logic [W-1:0]      acc_q, acc_d;
    logic [W-1:0]      p_q, p_d;
    logic [FRAC_W-1:0] xr_q, xr_d;
    logic              negr_q, negr_d;
    logic [3:0]        k_q, k_d;
    logic              sat_q, sat_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [INT_W-1:0]  int_q, int_d;
    logic [FRAC_W-1:0] frac_q, frac_d;
    logic              ovf_q, ovf_d;

    // Full-width products, floored by dropping the low FRAC_W bits
    logic [W+FRAC_W-1:0] mul_full;
    logic [W+FRAC_W:0]   scale_full;
    logic [W+1:0]        t_ext;
    logic [W+1:0]        sum_pos;
    logic [W+1:0]        diff_neg;
    logic [W-1:0]        acc_next;
    logic                ovf_step;

    assign mul_full   = {{FRAC_W{1'b0}}, acc_q} * {{W{1'b0}}, xr_q};
    assign scale_full = {{(FRAC_W+1){1'b0}}, p_q} * {{W{1'b0}}, recip_rom[k_q]};
    assign t_ext      = {1'b0, scale_full[W+FRAC_W:FRAC_W]};
    assign sum_pos    = ONE + t_ext;
    // t <= 1.0 in neg mode, but clamp to zero rather than wrap
    assign diff_neg   = (t_ext > ONE) ? '0 : (ONE - t_ext);

    always_comb begin
        acc_next = '0;
        ovf_step = 1'b0;
        if (negr_q) begin
            acc_next = diff_neg[W-1:0];
        end else if (sum_pos[W+1:W] != 2'b00) begin
            // result no longer fits INT_W integer bits: saturate
            acc_next = '1;
            ovf_step = 1'b1;
        end else begin
            acc_next = sum_pos[W-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        p_d     = p_q;
        xr_d    = xr_q;
        negr_d  = negr_q;
        k_d     = k_q;
        sat_d   = sat_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        int_d   = int_q;
        frac_d  = frac_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    xr_d    = bus.x;
                    negr_d  = bus.neg;
                    acc_d   = ONE[W-1:0];
                    k_d     = 4'(TERMS);
                    sat_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                p_d     = mul_full[W+FRAC_W-1:FRAC_W];
                state_d = S_SCALE;
            end
            S_SCALE: begin
                acc_d = acc_next;
                sat_d = sat_q | ovf_step;
                if (k_q == 4'd1) begin
                    // outputs are loaded on entry so they are valid in DONE
                    int_d   = acc_next[W-1:FRAC_W];
                    frac_d  = acc_next[FRAC_W-1:0];
                    ovf_d   = sat_q | ovf_step;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    k_d     = k_q - 4'd1;
                    state_d = S_MUL;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            p_q     <= '0;
            xr_q    <= '0;
            negr_q  <= 1'b0;
            k_q     <= '0;
            sat_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            int_q   <= '0;
            frac_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            p_q     <= p_d;
            xr_q    <= xr_d;
            negr_q  <= negr_d;
            k_q     <= k_d;
            sat_q   <= sat_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            int_q   <= int_d;
            frac_q  <= frac_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.intpart  = int_q;
    assign bus.fracpart = frac_q;
    assign bus.ovf      = ovf_q;

    // low halves of the products are discarded by design (floor)
    logic unused_bits;
    assign unused_bits = ^{mul_full[FRAC_W-1:0], scale_full[FRAC_W-1:0]};
endmodule

// File: tb/tb_exponential_param.sv
// tb_exponential_param
// Three instances: default (FRAC_W=16, INT_W=2, TERMS=8), INT_W=1 and
// TERMS=4. Table of directed vectors plus hand-written handshake,
// back-to-back and mid-run reset sequences.
module tb_exponential_param;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    exponential_param_if #(.FRAC_W(16), .INT_W(2)) if0 ();
    exponential_param_if #(.FRAC_W(16), .INT_W(1)) if1 ();
    exponential_param_if #(.FRAC_W(16), .INT_W(2)) if2 ();

    exponential_param #(.FRAC_W(16), .INT_W(2), .TERMS(8)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    exponential_param #(.FRAC_W(16), .INT_W(1), .TERMS(8)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
    exponential_param #(.FRAC_W(16), .INT_W(2), .TERMS(4)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          sel;
        logic [15:0] x;
        logic        neg;
        int          e_int;
        int          e_frac;
        int          tol;
        int          e_ovf;
        int          e_lat;
    } vec_t;

    vec_t vecs [10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int sel, input logic s, input logic n, input logic [15:0] xv);
        case (sel)
            0:       begin if0.start = s; if0.neg = n; if0.x = xv; end
            1:       begin if1.start = s; if1.neg = n; if1.x = xv; end
            default: begin if2.start = s; if2.neg = n; if2.x = xv; end
        endcase
    endtask

    function automatic int get_done(input int sel);
        case (sel)
            0:       return int'(if0.done);
            1:       return int'(if1.done);
            default: return int'(if2.done);
        endcase
    endfunction

    function automatic int get_busy(input int sel);
        case (sel)
            0:       return int'(if0.busy);
            1:       return int'(if1.busy);
            default: return int'(if2.busy);
        endcase
    endfunction

    function automatic int get_int(input int sel);
        case (sel)
            0:       return int'(if0.intpart);
            1:       return int'(if1.intpart);
            default: return int'(if2.intpart);
        endcase
    endfunction

    function automatic int get_frac(input int sel);
        case (sel)
            0:       return int'(if0.fracpart);
            1:       return int'(if1.fracpart);
            default: return int'(if2.fracpart);
        endcase
    endfunction

    function automatic int get_ovf(input int sel);
        case (sel)
            0:       return int'(if0.ovf);
            1:       return int'(if1.ovf);
            default: return int'(if2.ovf);
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp, input int tol);
        checks++;
        if (act < exp - tol || act > exp + tol) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", name, act, exp, tol);
        end
    endtask

    task automatic wait_idle(input int sel);
        int n;
        n = 0;
        while (get_busy(sel) != 0 && n < 60) begin
            tick();
            n++;
        end
        if (n >= 60) check("wait_idle timeout", 1, 0, 0);
    endtask

    // Pulse start for one accepted edge, then count cycles until done.
    task automatic run(input int sel, input logic [15:0] xv, input logic n,
                       output int lat, output int ip, output int fp, output int ov);
        wait_idle(sel);
        set_in(sel, 1'b1, n, xv);
        tick();
        set_in(sel, 1'b0, ~n, ~xv);   // later operand changes must not matter
        lat = -1;
        for (int c = 1; c <= 100; c++) begin
            tick();
            if (get_done(sel) != 0) begin
                lat = c;
                break;
            end
        end
        ip = get_int(sel);
        fp = get_frac(sel);
        ov = get_ovf(sel);
    endtask

    initial begin
        int lat, ip, fp, ov;
        int done_cnt, busy_ok, first_d, second_d, busy_after;
        string nm;

        vecs[0] = '{0, 16'h0000, 1'b0, 1,     0, 0, 0, 16};
        vecs[1] = '{0, 16'h0000, 1'b1, 1,     0, 0, 0, 16};
        vecs[2] = '{0, 16'h8000, 1'b0, 1, 42515, 4, 0, 16};
        vecs[3] = '{0, 16'h8000, 1'b1, 0, 39750, 4, 0, 16};
        vecs[4] = '{0, 16'hFFFF, 1'b0, 2, 47070, 4, 0, 16};
        vecs[5] = '{1, 16'hFFFF, 1'b0, 1, 65535, 0, 1, 16};
        vecs[6] = '{1, 16'h8000, 1'b1, 0, 39750, 4, 0, 16};
        vecs[7] = '{1, 16'h0000, 1'b0, 1,     0, 0, 0, 16};
        vecs[8] = '{2, 16'h8000, 1'b0, 1, 42496, 4, 0,  8};
        vecs[9] = '{2, 16'h0000, 1'b1, 1,     0, 0, 0,  8};

        for (int s = 0; s < 3; s++) set_in(s, 1'b0, 1'b0, 16'h0000);

        // reset held for 3 cycles, outputs cleared
        rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        for (int s = 0; s < 3; s++) begin
            $sformat(nm, "reset dut%0d", s);
            check({nm, " busy"}, get_busy(s), 0, 0);
            check({nm, " done"}, get_done(s), 0, 0);
            check({nm, " int"},  get_int(s),  0, 0);
            check({nm, " frac"}, get_frac(s), 0, 0);
            check({nm, " ovf"},  get_ovf(s),  0, 0);
        end

        for (int i = 0; i < 10; i++) begin
            run(vecs[i].sel, vecs[i].x, vecs[i].neg, lat, ip, fp, ov);
            $sformat(nm, "vec%0d", i);
            check({nm, " latency"}, lat, vecs[i].e_lat, 0);
            check({nm, " intpart"}, ip, vecs[i].e_int, 0);
            check({nm, " fracpart"}, fp, vecs[i].e_frac, vecs[i].tol);
            check({nm, " ovf"}, ov, vecs[i].e_ovf, 0);
        end

        // start pulses at cycles 3 and 10 of a run are ignored
        wait_idle(0);
        set_in(0, 1'b1, 1'b0, 16'h8000);
        tick();
        done_cnt = 0; busy_ok = 1; busy_after = -1; ip = -1; fp = -1;
        for (int c = 1; c <= 25; c++) begin
            if (c == 3 || c == 10) set_in(0, 1'b1, 1'b1, 16'hFFFF);
            else                   set_in(0, 1'b0, 1'b1, 16'hFFFF);
            tick();
            if (get_done(0) != 0) begin
                done_cnt++;
                ip = get_int(0);
                fp = get_frac(0);
            end
            if (c <= 16 && get_busy(0) == 0) busy_ok = 0;
            if (c == 17) busy_after = get_busy(0);
        end
        check("ignore start done count", done_cnt, 1, 0);
        check("ignore start busy held", busy_ok, 1, 0);
        check("ignore start busy drop", busy_after, 0, 0);
        check("ignore start intpart", ip, 1, 0);
        check("ignore start fracpart", fp, 42515, 4);

        // start held high for 40 cycles: back-to-back runs, 18 cycles apart
        wait_idle(0);
        set_in(0, 1'b1, 1'b0, 16'h8000);
        done_cnt = 0; first_d = -1; second_d = -1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (get_done(0) != 0) begin
                done_cnt++;
                if (first_d < 0) first_d = c;
                else if (second_d < 0) second_d = c;
            end
        end
        set_in(0, 1'b0, 1'b0, 16'h0000);
        check("held start done count", done_cnt, 2, 0);
        check("held start period", second_d - first_d, 18, 0);
        wait_idle(0);

        // reset asserted at cycle 7 of a run
        set_in(0, 1'b1, 1'b0, 16'hFFFF);
        tick();
        set_in(0, 1'b0, 1'b0, 16'h0000);
        repeat (6) tick();
        rst = 1'b0;
        #1;
        check("midreset busy", get_busy(0), 0, 0);
        check("midreset done", get_done(0), 0, 0);
        check("midreset int",  get_int(0),  0, 0);
        check("midreset frac", get_frac(0), 0, 0);
        check("midreset ovf",  get_ovf(0),  0, 0);
        tick();
        rst = 1'b1;
        done_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (get_done(0) != 0) done_cnt++;
        end
        check("midreset no done", done_cnt, 0, 0);
        run(0, 16'h8000, 1'b1, lat, ip, fp, ov);
        check("after reset latency", lat, 16, 0);
        check("after reset intpart", ip, 0, 0);
        check("after reset fracpart", fp, 39750, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/exponential_param.md
# exponential_param

Parametrised successor to the team's fixed 16-bit exponential unit. It computes e^x or e^-x for an unsigned fixed-point fraction x in [0,1) using a Horner-form Taylor series with a configurable term count. It uses one shared multiplier and a start/busy/done handshake. The block sits as a multi-cycle arithmetic slave under a controller FSM that pulses `start` and waits for `done`.

## Interface
- `FRAC_W`, default 16: fraction width of `x` and `fracpart`.
- `INT_W`, default 2: width of `intpart`. INT_W=2 covers e^x < 3.
- `TERMS`, default 8: number of Taylor terms (k = TERMS down to 1), range 1..15.

- `clk`  in  1: single clock, rising-edge.
- `rst`  in  1: asynchronous, active-low reset.
- `start`  in  1: request. Sampled only in IDLE.
- `neg`  in  1: 0 computes e^x, 1 computes e^-x. Sampled with `start`.
- `x`  in  FRAC_W: operand, value x/2^FRAC_W. Sampled with `start`.
- `busy`  out  1: high from the cycle after an accepted start through the DONE cycle.
- `done`  out  1: one-cycle pulse when the result becomes valid.
- `intpart`  out  INT_W: integer part of the result.
- `fracpart`  out  FRAC_W: fraction part of the result.
- `ovf`  out  1: result saturated. Valid with `done` and held with the result.

## Operation
- Accumulator `acc` is unsigned, INT_W+FRAC_W bits. Captured operands are `xr` and `negr`. Down-counter `k` is 4 bits.
- Reciprocal ROM: `recip(k) = round(2^FRAC_W / k)` for k=1..TERMS, FRAC_W+1 bits wide (recip(1) = 2^FRAC_W exactly).
- FSM states: IDLE, MUL, SCALE, DONE.
- IDLE: when `start`=1, latch `x` and `neg`, set acc = 1.0, k = TERMS, then go to MUL. When `start`=0, stay in IDLE.
- MUL: `p = floor(acc*xr / 2^FRAC_W)`, then go to SCALE.
- SCALE: `t = floor(p*recip(k) / 2^FRAC_W)`. Set acc = 1.0 + t if negr=0, or 1.0 − t if negr=1.
  - If k=1, go to DONE. Otherwise decrement k and go to MUL.
- DONE: register `{intpart, fracpart}` from acc and set `done`=1 for this cycle only, then go to IDLE.
- Overflow: when INT_W cannot hold the result (for example INT_W=1 with e^x ≥ 2), `intpart` and `fracpart` saturate to all ones and `ovf`=1.
- Underflow cannot occur: in neg mode t ≤ 1.0, so the result is floored at 0.
- All truncation is floor. Intermediate products are kept at full width before the shift.
- `start` in MUL, SCALE or DONE is ignored; it is neither queued nor restarts the run. Changes on `x` or `neg` after acceptance have no effect.
- Outputs hold their last result until the next DONE. A new run does not clear them early.

## Timing
- Reset (rst=0, asynchronous): state goes to IDLE and busy, done, intpart, fracpart and ovf all go to 0. This applies mid-run as well: the run is aborted and no `done` is issued.
- Latency: with start accepted at edge E0, `done` is high in the cycle after edge E0 + 2·TERMS (16 cycles at TERMS=8). The result is valid in that same cycle.
- `busy` = (state ≠ IDLE). It drops in the cycle after `done`.
- Back-to-back runs: `start` held high is accepted in the first IDLE cycle after DONE. The minimum period is 2·TERMS+2 cycles.
- Moore outputs only. There is no combinational path from inputs to outputs.

## Test plan
Defaults are FRAC_W=16, INT_W=2, TERMS=8 unless stated. Tolerance is ±4 LSB where given.
- Reset/zero: rst=0 for 3 cycles, then release. Check all outputs are 0. Then x=0, neg=0, start pulse → done exactly 16 cycles later with intpart=1, fracpart=0, ovf=0. Repeat with neg=1 → same result.
- Midpoint: x=16'h8000, neg=0 → intpart=1, fracpart=42515±4. Same x with neg=1 → intpart=0, fracpart=39750±4.
- Full scale: x=16'hFFFF, neg=0 → intpart=2, fracpart=47070±4, ovf=0.
- Handshake: pulse start again at cycles 3 and 10 of a run with different x → ignored; the result matches the first x, only one `done` pulse occurs, and busy is continuously high. Holding start high for 40 cycles → two done pulses, 18 cycles apart.
- Mid-run reset: assert rst at cycle 7 → busy and outputs are 0 immediately with no done. A fresh start afterwards gives the correct result.
- Parameter sweep: INT_W=1 with x=16'hFFFF → intpart=1, fracpart=16'hFFFF, ovf=1. TERMS=4 → done at 8 cycles, and x=16'h8000 gives fracpart=42496±4 (truncated series 1.6484).
